// File: rtl/tictactoe.sv
// ---------------------------------------------------------------------------
// tictactoe
//   Two-player 3x3 tic-tac-toe engine. Accepts one move per request,
//   alternates players starting with X, ignores illegal moves and reports a
//   winner or a tie. All outputs come straight from registers.
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   x_in       in   4   move row, 0..2 legal
//   y_in       in   4   move column, 0..2 legal
//   make_move  in   1   move request, sampled on rising clk
//   winner     out  2   00 none, 01 X won, 10 O won
//   tie        out  1   board full with no winner
//   board      out  18  packed row-major board, cell(r,c) at [17-2*(3r+c) -: 2]
// ---------------------------------------------------------------------------
module tictactoe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  x_in,
  input  logic [3:0]  y_in,
  input  logic        make_move,
  output logic [1:0]  winner,
  output logic        tie,
  output logic [17:0] board
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [17:0] r_board, w_board_nxt;
  logic        r_turn,  w_turn_nxt;   // 0 = X to move, 1 = O to move
  logic [1:0]  r_winner, w_winner_nxt;
  logic        r_tie,   w_tie_nxt;

  logic [1:0]  w_cell [9];
  logic [3:0]  w_idx;
  logic        w_in_range;
  logic [1:0]  w_target;
  logic        w_legal;
  logic [1:0]  w_code;
  logic [1:0]  w_line_win;
  logic        w_full;

  // Returns the common code when all three cells match and are occupied.
  function automatic logic [1:0] f_line(input logic [1:0] a,
                                        input logic [1:0] b,
                                        input logic [1:0] c);
    return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
  endfunction

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      w_cell[i] = r_board[17-2*i -: 2];
    end
  end

  // Range check must pass before the low index bits are trusted.
  assign w_in_range = (x_in <= 4'd2) && (y_in <= 4'd2);
  assign w_idx      = 4'(x_in[1:0]) * 4'd3 + 4'(y_in[1:0]);
  assign w_code     = r_turn ? 2'b10 : 2'b01;

  always_comb begin
    w_target = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (w_idx == 4'(i)) w_target = w_cell[i];
    end
  end

  assign w_legal = w_in_range && (w_target == 2'b00);

  // Only the player who just moved can complete a line, so a simple
  // priority chain over the eight lines is sufficient.
  always_comb begin
    w_line_win = f_line(w_cell[0], w_cell[1], w_cell[2]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[3], w_cell[4], w_cell[5]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[6], w_cell[7], w_cell[8]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[0], w_cell[3], w_cell[6]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[1], w_cell[4], w_cell[7]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[2], w_cell[5], w_cell[8]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[0], w_cell[4], w_cell[8]);
    if (w_line_win == 2'b00) w_line_win = f_line(w_cell[2], w_cell[4], w_cell[6]);
  end

  always_comb begin
    w_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (w_cell[i] == 2'b00) w_full = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_board_nxt  = r_board;
    w_turn_nxt   = r_turn;
    w_winner_nxt = r_winner;
    w_tie_nxt    = r_tie;
    case (r_state)
      S_IDLE: begin
        if (make_move && w_legal) begin
          for (int i = 0; i < 9; i++) begin
            if (w_idx == 4'(i)) w_board_nxt[17-2*i -: 2] = w_code;
          end
          w_turn_nxt  = ~r_turn;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        // A win on the final move takes priority over a full board.
        if (w_line_win != 2'b00) begin
          w_winner_nxt = w_line_win;
          w_state_nxt  = S_OVER;
        end else if (w_full) begin
          w_tie_nxt   = 1'b1;
          w_state_nxt = S_OVER;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OVER: begin
        w_state_nxt = S_OVER;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_board  <= 18'h0;
      r_turn   <= 1'b0;
      r_winner <= 2'b00;
      r_tie    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_board  <= w_board_nxt;
      r_turn   <= w_turn_nxt;
      r_winner <= w_winner_nxt;
      r_tie    <= w_tie_nxt;
    end
  end

  assign board  = r_board;
  assign winner = r_winner;
  assign tie    = r_tie;

endmodule

// File: tb/tb_tictactoe.sv
// ---------------------------------------------------------------------------
// tb_tictactoe
//   Scoreboard bench for tictactoe. A behavioural game model predicts board,
//   winner and tie for every request; predictions are queued when a move is
//   driven and popped when the corresponding DUT output is sampled.
// ---------------------------------------------------------------------------
module tb_tictactoe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  x_in;
  logic [3:0]  y_in;
  logic        make_move;
  logic [1:0]  winner;
  logic        tie;
  logic [17:0] board;

  tictactoe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .y_in      (y_in),
    .make_move (make_move),
    .winner    (winner),
    .tie       (tie),
    .board     (board)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] board;
    logic [1:0]  winner;
    logic        tie;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   m_cell [9];
  int   m_turn;
  int   m_win;
  int   m_tie;
  bit   m_over;
  int   lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] m_pack();
    logic [17:0] p;
    p = '0;
    for (int i = 0; i < 9; i++) p[17-2*i -: 2] = 2'(m_cell[i]);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
    m_turn = 0;
    m_win  = 0;
    m_tie  = 0;
    m_over = 1'b0;
  endtask

  task automatic model_move(input int x, input int y);
    int full;
    if (!m_over && x <= 2 && y <= 2 && m_cell[3*x+y] == 0) begin
      m_cell[3*x+y] = (m_turn == 0) ? 1 : 2;
      m_turn = 1 - m_turn;
      for (int l = 0; l < 8; l++) begin
        if (m_cell[lines[l][0]] != 0 &&
            m_cell[lines[l][0]] == m_cell[lines[l][1]] &&
            m_cell[lines[l][1]] == m_cell[lines[l][2]])
          m_win = m_cell[lines[l][0]];
      end
      full = 1;
      for (int i = 0; i < 9; i++) if (m_cell[i] == 0) full = 0;
      if (m_win != 0) m_over = 1'b1;
      else if (full != 0) begin
        m_tie  = 1;
        m_over = 1'b1;
      end
    end
  endtask

  task automatic push_now();
    exp_t e;
    e = '{board: m_pack(), winner: 2'(m_win), tie: 1'(m_tie)};
    sb_q.push_back(e);
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, "_board"},  32'(board),  32'(e.board));
      check_val({tag, "_winner"}, 32'(winner), 32'(e.winner));
      check_val({tag, "_tie"},    32'(tie),    32'(e.tie));
    end
  endtask

  // One request: board updates on the sampling edge, winner/tie one edge later.
  task automatic do_move(input int x, input int y, input string tag);
    exp_t e1;
    logic [1:0] pw;
    logic       pt;
    pw = 2'(m_win);
    pt = 1'(m_tie);
    model_move(x, y);
    e1 = '{board: m_pack(), winner: pw, tie: pt};
    sb_q.push_back(e1);
    push_now();
    @(negedge clk);
    x_in      = 4'(x);
    y_in      = 4'(y);
    make_move = 1'b1;
    @(posedge clk);
    #1;
    make_move = 1'b0;
    compare_pop({tag, "_e1"});
    @(posedge clk);
    #1;
    compare_pop({tag, "_e2"});
  endtask

  // Reset asserted between edges to confirm it acts immediately.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    push_now();
    compare_pop(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    make_move = 1'b0;
    x_in      = 4'd0;
    y_in      = 4'd0;
    model_reset();
    #1;
    push_now();
    compare_pop("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    push_now();
    compare_pop("idle");

    // X wins the top row
    do_move(0, 0, "g2m1");
    do_move(1, 0, "g2m2");
    do_move(0, 1, "g2m3");
    do_move(1, 1, "g2m4");
    do_move(0, 2, "g2m5");
    check_val("g2_row0", 32'(board[17:12]), 32'(6'b010101));
    check_val("g2_win",  32'(winner), 32'(2'b01));
    do_move(2, 2, "g2_after1");
    do_move(2, 1, "g2_after2");

    // O wins the anti-diagonal
    do_reset("rst_g3");
    do_move(0, 0, "g3m1");
    do_move(1, 1, "g3m2");
    do_move(0, 1, "g3m3");
    do_move(2, 2, "g3m4");
    do_move(1, 0, "g3m5");
    do_move(2, 0, "g3m6");
    do_move(2, 1, "g3m7");
    do_move(0, 2, "g3m8");
    check_val("g3_win", 32'(winner), 32'(2'b10));

    // Full board, no line
    do_reset("rst_g4");
    do_move(0, 0, "g4m1");
    do_move(1, 1, "g4m2");
    do_move(2, 2, "g4m3");
    do_move(0, 2, "g4m4");
    do_move(2, 0, "g4m5");
    do_move(1, 0, "g4m6");
    do_move(1, 2, "g4m7");
    do_move(2, 1, "g4m8");
    do_move(0, 1, "g4m9");
    check_val("g4_tie", 32'(tie), 32'd1);
    check_val("g4_win", 32'(winner), 32'(2'b00));
    do_move(0, 0, "g4_after");

    // X wins on the ninth move: win only, no tie
    do_reset("rst_g9");
    do_move(0, 0, "g9m1");
    do_move(0, 1, "g9m2");
    do_move(0, 2, "g9m3");
    do_move(1, 0, "g9m4");
    do_move(1, 1, "g9m5");
    do_move(1, 2, "g9m6");
    do_move(2, 1, "g9m7");
    do_move(2, 0, "g9m8");
    do_move(2, 2, "g9m9");
    check_val("g9_win", 32'(winner), 32'(2'b01));
    check_val("g9_tie", 32'(tie), 32'd0);

    // Illegal moves leave board and turn alone
    do_reset("rst_g5");
    do_move(0, 0, "g5x");
    do_move(0, 0, "g5_occ");
    do_move(3, 1, "g5_x3");
    do_move(15, 0, "g5_x15");
    do_move(1, 4, "g5_y4");
    do_move(4, 2, "g5_x4");
    do_move(1, 1, "g5o");
    check_val("g5_o_cell", 32'(board[9:8]), 32'(2'b10));
    check_val("g5_y4_cell", 32'(board[11:10]), 32'(2'b00));

    // Held request places one mark only
    do_reset("rst_hold");
    @(negedge clk);
    x_in      = 4'd2;
    y_in      = 4'd2;
    make_move = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    make_move = 1'b0;
    model_move(2, 2);
    push_now();
    compare_pop("hold");
    do_move(0, 0, "hold_next");
    check_val("hold_next_o", 32'(board[17:16]), 32'(2'b10));

    // Reset mid-game, then X moves first again
    do_move(1, 1, "mid1");
    do_reset("rst_mid");
    do_move(1, 1, "mid_after");
    check_val("mid_x", 32'(board[9:8]), 32'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
